// File: rtl/ycbcr_rgb_pkg.sv
// Shared definitions for the YCbCr-to-RGB colour path: channel tags, default
// channel width and the assembly FSM states used by the pixel packer.
package ycbcr_rgb_pkg;

    localparam int CH_W_DEF = 8;

    // Channel tags carried alongside each clamped channel beat. Tag 3 is illegal.
    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    // Packed pixels are {R,G,B} with R in the most significant channel slot.
    typedef enum logic [1:0] {
        EXP_R = 2'd0,
        EXP_G = 2'd1,
        EXP_B = 2'd2
    } asm_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a level counter. A push while full is
// accepted when a pop happens in the same cycle; otherwise it is dropped and flagged.
module sync_fifo_fwft #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       ready,
    output logic                       valid,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              full;
    logic              pop;
    logic              accept;

    assign full   = (level == LW'(DEPTH));
    assign valid  = (level != '0);
    assign pop    = valid & ready;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    // Head is zeroed while empty so the output reads 0 out of reset.
    assign head = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ycbcr_to_rgb_pixel_pack.sv
// Reassembles tagged R/G/B channel beats into 24-bit pixels, buffers them in a
// FWFT FIFO and reports sequencing and overflow faults through sticky flags.
module ycbcr_to_rgb_pixel_pack
    import ycbcr_rgb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CH_W  = CH_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_i,
    input  logic [1:0]               state_i,
    input  logic [CH_W-1:0]          chan_i,
    output logic                     pix_valid_o,
    input  logic                     pix_ready_i,
    output logic [3*CH_W-1:0]        pix_data_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     seq_err_o,
    output logic                     ovf_err_o,
    input  logic                     clr_err_i
);

    asm_state_t        state;
    asm_state_t        state_nx;
    logic              cap_r;
    logic              cap_g;
    logic              push;
    logic              seq_evt;
    logic              ovf_evt;
    logic [CH_W-1:0]   r_cap;
    logic [CH_W-1:0]   g_cap;
    logic [3*CH_W-1:0] pixel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EXP_R;
        end else begin
            state <= state_nx;
        end
    end

    // An out-of-order R always restarts the pixel rather than being discarded.
    always_comb begin
        state_nx = state;
        cap_r    = 1'b0;
        cap_g    = 1'b0;
        push     = 1'b0;
        seq_evt  = 1'b0;
        if (valid_i) begin
            case (state)
                EXP_R: begin
                    if (state_i == CH_R) begin
                        cap_r    = 1'b1;
                        state_nx = EXP_G;
                    end else begin
                        seq_evt  = 1'b1;
                    end
                end
                EXP_G: begin
                    if (state_i == CH_G) begin
                        cap_g    = 1'b1;
                        state_nx = EXP_B;
                    end else if (state_i == CH_R) begin
                        seq_evt  = 1'b1;
                        cap_r    = 1'b1;
                        state_nx = EXP_G;
                    end else begin
                        seq_evt  = 1'b1;
                        state_nx = EXP_R;
                    end
                end
                EXP_B: begin
                    if (state_i == CH_B) begin
                        push     = 1'b1;
                        state_nx = EXP_R;
                    end else if (state_i == CH_R) begin
                        seq_evt  = 1'b1;
                        cap_r    = 1'b1;
                        state_nx = EXP_G;
                    end else begin
                        seq_evt  = 1'b1;
                        state_nx = EXP_R;
                    end
                end
                default: state_nx = EXP_R;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap <= '0;
            g_cap <= '0;
        end else begin
            if (cap_r) begin
                r_cap <= chan_i;
            end
            if (cap_g) begin
                g_cap <= chan_i;
            end
        end
    end

    assign pixel = {r_cap, g_cap, chan_i};

    // A new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_err_o <= 1'b0;
            ovf_err_o <= 1'b0;
        end else begin
            seq_err_o <= seq_evt | (seq_err_o & ~clr_err_i);
            ovf_err_o <= ovf_evt | (ovf_err_o & ~clr_err_i);
        end
    end

    sync_fifo_fwft #(
        .DATA_W (3*CH_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (pixel),
        .ready     (pix_ready_i),
        .valid     (pix_valid_o),
        .head      (pix_data_o),
        .level     (fifo_level_o),
        .drop      (ovf_evt)
    );

endmodule

// File: doc/ycbcr_to_rgb_pixel_pack.md
Name: ycbcr_to_rgb_pixel_pack

Overview:
Downstream of the final YCbCr-to-RGB colour-stage pipeline, which emits one 8-bit clamped channel per valid beat, tagged by a 2-bit state (0=R, 1=G, 2=B).
- Reassembles the three serial channel beats into one 24-bit RGB pixel.
- Buffers pixels in a small first-word-fall-through FIFO.
- Presents pixels on a valid/ready interface to the display/output path.
- The upstream pipeline has no backpressure, so overflow and sequencing faults are reported through sticky flags.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
CH_W, 8, bits per colour channel

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
valid_i  in  1  channel beat valid (from colour stage valid_o)
state_i  in  2  channel tag: 0=R, 1=G, 2=B, 3=illegal
chan_i  in  CH_W  clamped channel value
pix_valid_o  out  1  FIFO head valid
pix_ready_i  in  1  consumer ready
pix_data_o  out  3*CH_W  head pixel {R,G,B}, R in MSBs
fifo_level_o  out  $clog2(DEPTH)+1  entries held
seq_err_o  out  1  sticky: out-of-order or illegal tag seen
ovf_err_o  out  1  sticky: completed pixel dropped because FIFO full
clr_err_i  in  1  clears both sticky flags

Behaviour:
Reset (rst_n=0 at posedge):
- FSM goes to EXP_R.
- Partial R/G capture registers are cleared.
- FIFO pointers and level go to 0.
- Outputs: pix_valid_o=0, pix_data_o=0, fifo_level_o=0, seq_err_o=0, ovf_err_o=0.
- Reset mid-pixel discards the partial pixel and all FIFO contents.

Assembly FSM (states EXP_R, EXP_G, EXP_B). Beats with valid_i=0 are ignored; the FSM holds state, so gaps of any length are allowed.
- EXP_R:
  - state_i=0: capture R, go to EXP_G.
  - Any other tag: set seq_err, discard, stay in EXP_R.
- EXP_G:
  - state_i=1: capture G, go to EXP_B.
  - state_i=0: set seq_err, recapture R, stay in EXP_G (restart).
  - Tag 2 or 3: set seq_err, discard, go to EXP_R.
- EXP_B:
  - state_i=2: form {R,G,chan_i}, issue push, go to EXP_R.
  - state_i=0: set seq_err, recapture R, go to EXP_G.
  - Tag 1 or 3: set seq_err, discard, go to EXP_R.

FIFO:
- Register array of DEPTH entries, read pointer and write pointer of $clog2(DEPTH) bits each, wrapping modulo DEPTH.
- Level register of $clog2(DEPTH)+1 bits.
- pop = pix_valid_o & pix_ready_i.
- push is accepted if level<DEPTH, or if level==DEPTH and pop occurs in the same cycle; the level is then unchanged.
- push while full with no pop: the pixel is dropped, ovf_err is set, and pointers are unchanged.
- Simultaneous push and pop when empty cannot occur; pix_valid_o is 0 when empty.
- pix_valid_o = (level!=0). pix_data_o = mem[rd_ptr], driven combinationally from the array. Holds stable while pix_valid_o=1 and pix_ready_i=0.
- pix_data_o while empty is don't-care. The bench checks it only when valid.

Latency:
- B beat at posedge N → pixel visible on pix_data_o with pix_valid_o=1 after posedge N+1 (one cycle), when the FIFO was empty.
- fifo_level_o updates in the same cycle.

Throughput: one pixel per 3 valid beats. The FIFO drains at one pixel per cycle.

Sticky flags:
- Set on the error event; held until clr_err_i=1 at a posedge.
- If an error and clr_err_i occur in the same cycle, set wins.
- Flags are registered; visible the cycle after the event.

Decomposition:
- Shared package ycbcr_rgb_pkg:
  - channel tag constants CH_R=2'd0, CH_G=2'd1, CH_B=2'd2.
  - CH_W default.
  - pixel packing order {R,G,B}.
  - The colour stages should also use these tags.
- One sub-module: sync_fifo_fwft (DATA_W, DEPTH), which owns pointers, level, full/empty, and same-cycle push-when-full-with-pop.
- The top holds the FSM, capture registers, and error flags.

Test Plan:
1. Beats (0,0x12),(1,0x34),(2,0x56) back-to-back, pix_ready_i=1 → one cycle after the B beat: pix_valid_o=1, pix_data_o=0x123456, level=1; next cycle level=0, valid=0.
2. Same three beats with 2 idle cycles between each, pix_ready_i=1 → identical single pixel 0x123456, seq_err_o=0.
3. Tags 0,2 then 0,1,2 with values 0xAA,0xBB,0xCC → after first pair seq_err_o=1, no push; then pixel 0xAABBCC. Also tags 0(0x11),0(0x22),1(0x33),2(0x44) → pixel 0x223344, seq_err_o=1.
4. DEPTH=4, pix_ready_i=0, push 5 pixels 0x010101..0x050505 → level=4, ovf_err_o=1. Then ready=1 drains 0x010101..0x040404 in order; clr_err_i clears both flags.
5. FIFO full, pix_ready_i=1 in the same cycle as a 5th pixel's B beat → push accepted, level stays 4, ovf_err_o=0, drain order intact.
6. R,G beats, then rst_n=0 for 1 cycle, then a lone (2,0x99) → no pixel, seq_err_o=1, level=0. Also tag 3 in any state → seq_err_o=1, FSM in EXP_R.
